servo_track_ctrl: RTL and testbench
===================================

Name: servo_track_ctrl

Overview:
Closed-loop pan/tilt scheduler that sits between the ball-detection coordinate output and the servo PWM generator. It latches target coordinates and computes a deadbanded, rate-limited, saturated duty update for each axis, applied exactly once per 20 ms servo frame. After a configurable loss timeout it ramps both servos back to the home position.

Parameters:
FRAME_CYC, 2_000_000, clock cycles per servo frame (20 ms at 10 ns)
DUTY_MIN, 50_000, minimum duty count (0.5 ms)
DUTY_MAX, 250_000, maximum duty count (2.5 ms)
DUTY_HOME, 150_000, home/centre duty count (1.5 ms)
CTR_X, 400, target x pixel centre
CTR_Y, 240, target y pixel centre
DEADBAND, 16, pixel error at or below which the axis holds its duty
KP, 4, duty counts per pixel of error
STEP_MAX, 2_500, maximum duty change per frame, both in tracking and in return ramp
LOST_FRAMES, 250, consecutive frames without a sample before RETURN (5 s)

Ports:
clk  in  1  system clock, same domain as PWM generator
rst_n  in  1  asynchronous active-low reset
x_pos  in  10  target x coordinate
y_pos  in  10  target y coordinate
coor_valid_flag  in  1  coordinate valid level; rising edge marks a new sample
frame_tick  out  1  one-cycle pulse at the last cycle of each frame
x_duty  out  18  pan duty count to PWM generator
y_duty  out  18  tilt duty count to PWM generator
duty_upd  out  1  one-cycle pulse in the cycle the duty registers change source sample/ramp
tracking  out  1  high in TRACK state

Behaviour:
- Reset (async, rst_n=0): x_duty=y_duty=DUTY_HOME; frame counter=0; frame_tick=0; duty_upd=0; tracking=0; pending=0; lost_cnt=0; state HOME.
- Frame counter runs 0..FRAME_CYC-1 and wraps. frame_tick is asserted when the count equals FRAME_CYC-1.
- Sample capture: coor_valid_flag is registered once and a rising edge is detected. On an edge, x_pos/y_pos are latched and pending is set. A later edge in the same frame overwrites the latch (latest wins).
- An edge coinciding with frame_tick is latched but is not consumed until the next tick.
- Per-axis error e = latched_pos - CTR (11-bit signed).
  - If |e| <= DEADBAND: no change.
  - Otherwise step = min(|e|*KP, STEP_MAX), computed at least 19 bits wide.
  - x: e>0 decreases x_duty, e<0 increases it. y: e>0 increases y_duty, e<0 decreases it.
  - The result saturates to [DUTY_MIN, DUTY_MAX] and never wraps.
- Duty registers update in the cycle after frame_tick (1-cycle latency). duty_upd pulses in that same cycle.
- FSM (evaluated on frame_tick only):
  - HOME: if pending, apply update, clear pending, lost_cnt=0, go to TRACK. Otherwise hold.
  - TRACK: if pending, apply update, clear pending, lost_cnt=0. Otherwise lost_cnt+1; when lost_cnt reaches LOST_FRAMES-1 on a sample-less tick, go to RETURN.
  - RETURN: if pending, apply the tracking update, go to TRACK. Otherwise move each axis toward DUTY_HOME by min(|duty-HOME|, STEP_MAX). When both axes equal DUTY_HOME after the step, go to HOME.
- duty_upd pulses on every consumed sample, even if the deadband leaves the duty unchanged, and on every RETURN ramp step. It does not pulse in HOME or on a sample-less TRACK tick.
- tracking is registered; it is high from the cycle after entering TRACK until the cycle after leaving it.
- Reset mid-operation: immediate home values. No partial ramp is retained.

Decomposition:
- Shared package servo_pkg: DUTY_MIN/MAX/HOME, FRAME_CYC, the state enum (HOME, TRACK, RETURN), and the 18-bit duty width.
- One natural sub-module: servo_axis_step. It is combinational and instanced twice: inputs pos, ctr, duty, dir_inv, return_mode; output next duty, implementing deadband, gain, step limit, saturation and home-ramp.

Test Plan:
Use FRAME_CYC=100 and LOST_FRAMES=4 for all benches.
1. Reset release -> x_duty=y_duty=150000, tracking=0; first frame_tick at cycle 99, then every 100 cycles.
2. Edge with x=500, y=240 -> the cycle after the next tick gives x_duty=149600 and y_duty=150000; duty_upd pulses once; tracking=1.
3. Edge with x=410, y=100 -> x unchanged (|e|=10 is within the deadband); y error -140 gives step min(560,2500)=560, so y_duty=149440.
4. Repeated edges with x=639 each frame -> x_duty decreases by 956 per frame and clamps at exactly 50000, with no wrap.
5. From x_duty=140000, no edges for 4 ticks -> RETURN; x_duty then steps 142500, 145000, 147500, 150000; state becomes HOME and tracking=0.
6. rst_n pulsed low mid-RETURN, plus an edge coincident with frame_tick -> outputs go home asynchronously. The coincident sample is applied only at the following tick.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo tracking controller.
// Holds the duty-count limits, the frame and loss-timeout defaults, the
// tracking-law constants and the controller state encoding.
package servo_pkg;

    localparam int unsigned DUTY_W = 18;

    localparam int unsigned FRAME_CYC   = 2_000_000;  // 20 ms at 10 ns
    localparam int unsigned LOST_FRAMES = 250;        // 5 s of missing samples

    localparam logic [DUTY_W-1:0] DUTY_MIN  = 18'd50_000;
    localparam logic [DUTY_W-1:0] DUTY_MAX  = 18'd250_000;
    localparam logic [DUTY_W-1:0] DUTY_HOME = 18'd150_000;

    localparam logic [9:0] CTR_X = 10'd400;
    localparam logic [9:0] CTR_Y = 10'd240;

    localparam int unsigned DEADBAND = 16;
    localparam int unsigned KP       = 4;
    localparam int unsigned STEP_MAX = 2_500;

    typedef enum logic [1:0] {
        StHome,
        StTrack,
        StReturn
    } state_e;

endpackage

// File: rtl/servo_track_ctrl_if.sv
// Coordinate-in / duty-out bundle of the servo tracking controller.
//   x_pos, y_pos     : target coordinate from the detector
//   coor_valid_flag  : valid level, rising edge marks a new sample
//   frame_tick       : pulse on the last cycle of each servo frame
//   x_duty, y_duty   : pan / tilt duty counts to the PWM generator
//   duty_upd         : pulse in the cycle the duty registers take a new value
//   tracking         : high while tracking a target
// master = detector/PWM side, slave = controller.
interface servo_track_ctrl_if;

    logic [9:0]                  x_pos;
    logic [9:0]                  y_pos;
    logic                        coor_valid_flag;
    logic                        frame_tick;
    logic [servo_pkg::DUTY_W-1:0] x_duty;
    logic [servo_pkg::DUTY_W-1:0] y_duty;
    logic                        duty_upd;
    logic                        tracking;

    modport master (
        output x_pos, y_pos, coor_valid_flag,
        input  frame_tick, x_duty, y_duty, duty_upd, tracking
    );

    modport slave (
        input  x_pos, y_pos, coor_valid_flag,
        output frame_tick, x_duty, y_duty, duty_upd, tracking
    );

endinterface

// File: rtl/servo_axis_step.sv
// Combinational next-duty computation for one servo axis.
//   pos_i, ctr_i   : latched target pixel and axis centre
//   duty_i         : current duty count
//   dir_inv_i      : 1 = a positive pixel error decreases the duty
//   return_mode_i  : 1 = ramp toward DUTY_HOME instead of tracking
//   duty_o         : next duty count, saturated to [DUTY_MIN, DUTY_MAX]
module servo_axis_step
    import servo_pkg::*;
(
    input  logic [9:0]        pos_i,
    input  logic [9:0]        ctr_i,
    input  logic [DUTY_W-1:0] duty_i,
    input  logic              dir_inv_i,
    input  logic              return_mode_i,
    output logic [DUTY_W-1:0] duty_o
);

    localparam logic [18:0]        StepLim = 19'(STEP_MAX);
    localparam logic signed [19:0] MinS    = $signed(20'(DUTY_MIN));
    localparam logic signed [19:0] MaxS    = $signed(20'(DUTY_MAX));

    logic signed [10:0] err;
    logic [10:0]        err_abs;
    logic [18:0]        gain_step;
    logic [DUTY_W-1:0]  home_dist;
    logic [18:0]        step;
    logic               dec;
    logic signed [19:0] sum;

    always_comb begin
        err       = $signed({1'b0, pos_i}) - $signed({1'b0, ctr_i});
        err_abs   = err[10] ? 11'(-err) : 11'(err);
        gain_step = 19'(err_abs) * 19'(KP);
        home_dist = (duty_i > DUTY_HOME) ? (duty_i - DUTY_HOME) : (DUTY_HOME - duty_i);
        step      = '0;
        dec       = 1'b0;

        if (return_mode_i) begin
            dec  = duty_i > DUTY_HOME;
            step = (19'(home_dist) > StepLim) ? StepLim : 19'(home_dist);
        end else if (err_abs > 11'(DEADBAND)) begin
            step = (gain_step > StepLim) ? StepLim : gain_step;
            // Positive error moves the duty down when the axis is inverted.
            dec  = err[10] ? ~dir_inv_i : dir_inv_i;
        end

        // 20-bit signed sum cannot wrap, so clamping is exact at both ends.
        sum = dec ? ($signed({2'b00, duty_i}) - $signed({1'b0, step}))
                  : ($signed({2'b00, duty_i}) + $signed({1'b0, step}));

        if (sum < MinS) begin
            duty_o = DUTY_MIN;
        end else if (sum > MaxS) begin
            duty_o = DUTY_MAX;
        end else begin
            duty_o = sum[DUTY_W-1:0];
        end
    end

endmodule

// File: rtl/servo_track_ctrl.sv
// Pan/tilt servo scheduler between ball detection and the PWM generator.
// Latches the latest coordinate sample and, once per servo frame, applies a
// deadbanded, rate-limited, saturated duty update per axis. After LostFrames
// sample-less frames it ramps both axes back to DUTY_HOME.
//   clk, rst_n : clock and asynchronous active-low reset
//   trk_io     : coordinate inputs and duty/status outputs (slave side)
module servo_track_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned FrameCyc   = FRAME_CYC,
    parameter int unsigned LostFrames = LOST_FRAMES
) (
    input logic               clk,
    input logic               rst_n,
    servo_track_ctrl_if.slave trk_io
);

    localparam int unsigned     CntW    = $clog2(FrameCyc);
    localparam int unsigned     LostW   = $clog2(LostFrames) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FrameCyc - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              valid_q;
    logic              pending_q, pending_d;
    logic [9:0]        x_lat_q, y_lat_q;
    state_e            state_q, state_d;
    logic [LostW-1:0]  lost_q, lost_d;
    logic [DUTY_W-1:0] x_duty_q, x_duty_d, y_duty_q, y_duty_d;
    logic              upd_q, upd_d;
    logic              trk_q;

    logic              tick;
    logic              edge_det;
    logic              ret_mode;
    logic [DUTY_W-1:0] x_next, y_next;

    assign tick     = (cnt_q == CntLast);
    assign edge_det = trk_io.coor_valid_flag & ~valid_q;
    assign cnt_d    = tick ? '0 : cnt_q + 1'b1;
    // A new edge in the tick cycle re-arms pending for the next frame.
    assign pending_d = edge_det | (pending_q & ~tick);
    // A pending sample in RETURN takes priority over the home ramp.
    assign ret_mode  = (state_q == StReturn) & ~pending_q;

    servo_axis_step u_axis_x (
        .pos_i        (x_lat_q),
        .ctr_i        (CTR_X),
        .duty_i       (x_duty_q),
        .dir_inv_i    (1'b1),
        .return_mode_i(ret_mode),
        .duty_o       (x_next)
    );

    servo_axis_step u_axis_y (
        .pos_i        (y_lat_q),
        .ctr_i        (CTR_Y),
        .duty_i       (y_duty_q),
        .dir_inv_i    (1'b0),
        .return_mode_i(ret_mode),
        .duty_o       (y_next)
    );

    always_comb begin
        state_d  = state_q;
        lost_d   = lost_q;
        x_duty_d = x_duty_q;
        y_duty_d = y_duty_q;
        upd_d    = 1'b0;

        if (tick) begin
            case (state_q)
                StHome: begin
                    if (pending_q) begin
                        x_duty_d = x_next;
                        y_duty_d = y_next;
                        upd_d    = 1'b1;
                        lost_d   = '0;
                        state_d  = StTrack;
                    end
                end
                StTrack: begin
                    if (pending_q) begin
                        x_duty_d = x_next;
                        y_duty_d = y_next;
                        upd_d    = 1'b1;
                        lost_d   = '0;
                    end else begin
                        lost_d = lost_q + 1'b1;
                        if (lost_q == LostW'(LostFrames - 1)) begin
                            state_d = StReturn;
                        end
                    end
                end
                StReturn: begin
                    x_duty_d = x_next;
                    y_duty_d = y_next;
                    upd_d    = 1'b1;
                    if (pending_q) begin
                        lost_d  = '0;
                        state_d = StTrack;
                    end else if (x_next == DUTY_HOME && y_next == DUTY_HOME) begin
                        state_d = StHome;
                    end
                end
                default: state_d = StHome;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            x_lat_q   <= '0;
            y_lat_q   <= '0;
            state_q   <= StHome;
            lost_q    <= '0;
            x_duty_q  <= DUTY_HOME;
            y_duty_q  <= DUTY_HOME;
            upd_q     <= 1'b0;
            trk_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            valid_q   <= trk_io.coor_valid_flag;
            pending_q <= pending_d;
            if (edge_det) begin
                x_lat_q <= trk_io.x_pos;
                y_lat_q <= trk_io.y_pos;
            end
            state_q  <= state_d;
            lost_q   <= lost_d;
            x_duty_q <= x_duty_d;
            y_duty_q <= y_duty_d;
            upd_q    <= upd_d;
            trk_q    <= (state_d == StTrack);
        end
    end

    assign trk_io.frame_tick = tick;
    assign trk_io.x_duty     = x_duty_q;
    assign trk_io.y_duty     = y_duty_q;
    assign trk_io.duty_upd   = upd_q;
    assign trk_io.tracking   = trk_q;

endmodule

// File: tb/tb_servo_track_ctrl.sv
// Self-checking bench for servo_track_ctrl with a 100-cycle frame and a
// 4-frame loss timeout. Expected duty pairs are queued when a sample or ramp
// step is expected and popped whenever the DUT pulses duty_upd.
module tb_servo_track_ctrl;
    import servo_pkg::*;

    localparam int unsigned FC = 100;
    localparam int unsigned LF = 4;

    typedef struct {
        logic [9:0]        x;
        logic [9:0]        y;
        logic [DUTY_W-1:0] ex;
        logic [DUTY_W-1:0] ey;
    } vec_t;

    typedef struct {
        logic [DUTY_W-1:0] ex;
        logic [DUTY_W-1:0] ey;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    servo_track_ctrl_if trk_if ();

    servo_track_ctrl #(
        .FrameCyc  (FC),
        .LostFrames(LF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .trk_io(trk_if)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    logic tick_prev = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Scoreboard: every duty_upd must follow a tick and match the queue head.
    always @(negedge clk) begin
        if (rst_n && trk_if.duty_upd) begin
            check("upd_after_tick", longint'(tick_prev), 1);
            if (exp_q.size() == 0) begin
                check("upd_expected", longint'(trk_if.duty_upd), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_x_duty", longint'(trk_if.x_duty), longint'(e.ex));
                check("sb_y_duty", longint'(trk_if.y_duty), longint'(e.ey));
            end
        end
        tick_prev = rst_n & trk_if.frame_tick;
    end

    task automatic wait_tick(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles <= int'(2 * FC)) begin
            @(negedge clk);
            cycles++;
            seen = trk_if.frame_tick;
        end
        if (!seen) check("tick_timeout", cycles, FC);
    endtask

    task automatic send_sample(input logic [9:0] x, input logic [9:0] y);
        @(posedge clk);
        #1;
        trk_if.x_pos           = x;
        trk_if.y_pos           = y;
        trk_if.coor_valid_flag = 1'b1;
        @(posedge clk);
        #1;
        trk_if.coor_valid_flag = 1'b0;
    endtask

    // Sample mid-frame, expect it applied in the cycle after the next tick.
    task automatic run_frame(input logic [9:0] x, input logic [9:0] y,
                             input logic [DUTY_W-1:0] ex, input logic [DUTY_W-1:0] ey);
        int c;
        send_sample(x, y);
        exp_q.push_back('{ex: ex, ey: ey});
        wait_tick(c);
        @(negedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);
        check("tracking_on", longint'(trk_if.tracking), 1);
    endtask

    task automatic idle_ticks(input int n);
        int c;
        for (int i = 0; i < n; i++) wait_tick(c);
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t   vecs[7];
        int     c;
        int     hold;
        longint ex;

        trk_if.x_pos           = '0;
        trk_if.y_pos           = '0;
        trk_if.coor_valid_flag = 1'b0;

        vecs[0] = '{x: 10'd500,  y: 10'd240,  ex: 18'd149600, ey: 18'd150000};
        vecs[1] = '{x: 10'd410,  y: 10'd100,  ex: 18'd149600, ey: 18'd149440};
        vecs[2] = '{x: 10'd300,  y: 10'd480,  ex: 18'd150000, ey: 18'd150400};
        vecs[3] = '{x: 10'd0,    y: 10'd0,    ex: 18'd151600, ey: 18'd149440};
        vecs[4] = '{x: 10'd1023, y: 10'd1023, ex: 18'd149108, ey: 18'd151940};
        vecs[5] = '{x: 10'd416,  y: 10'd256,  ex: 18'd149108, ey: 18'd151940};
        vecs[6] = '{x: 10'd417,  y: 10'd223,  ex: 18'd149040, ey: 18'd151872};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_x_duty", longint'(trk_if.x_duty), 150000);
        check("rst_y_duty", longint'(trk_if.y_duty), 150000);
        check("rst_tracking", longint'(trk_if.tracking), 0);
        check("rst_duty_upd", longint'(trk_if.duty_upd), 0);
        check("rst_frame_tick", longint'(trk_if.frame_tick), 0);

        rst_n = 1'b1;
        wait_tick(c);
        check("first_tick", c, 99);
        wait_tick(c);
        check("tick_period", c, 100);

        // Table: gain, deadband boundary, step limit, both directions
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].x, vecs[i].y, vecs[i].ex, vecs[i].ey);
        end

        // Repeated x=639: -956 per frame down to the lower clamp
        ex   = 149040;
        hold = 0;
        for (int f = 0; f < 200 && hold < 2; f++) begin
            ex = (ex >= 50000 + 956) ? ex - 956 : 50000;
            if (ex == 50000) hold++;
            run_frame(10'd639, 10'd240, DUTY_W'(ex), 18'd151872);
        end
        check("clamp_x", longint'(trk_if.x_duty), 50000);

        // Loss timeout, two ramp steps, then async reset mid-RETURN
        idle_ticks(3);
        check("track_before_timeout", longint'(trk_if.tracking), 1);
        idle_ticks(1);
        check("return_tracking_off", longint'(trk_if.tracking), 0);
        exp_q.push_back('{ex: 18'd52500, ey: 18'd150000});
        idle_ticks(1);
        exp_q.push_back('{ex: 18'd55000, ey: 18'd150000});
        idle_ticks(1);
        #1;
        check("ramp_drained", exp_q.size(), 0);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_x", longint'(trk_if.x_duty), 150000);
        check("async_rst_y", longint'(trk_if.y_duty), 150000);
        check("async_rst_trk", longint'(trk_if.tracking), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(c);
        check("first_tick_after_rst", c, 99);

        // Walk x to 140000, then time out and ramp home
        for (int k = 1; k <= 5; k++) begin
            run_frame(10'd900, 10'd240, DUTY_W'(150000 - 2000 * k), 18'd150000);
        end
        idle_ticks(3);
        check("track_hold", longint'(trk_if.tracking), 1);
        idle_ticks(1);
        check("return_entered", longint'(trk_if.tracking), 0);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back('{ex: DUTY_W'(140000 + 2500 * k), ey: 18'd150000});
            idle_ticks(1);
            #1;
            check("home_ramp_drained", exp_q.size(), 0);
        end
        check("home_x", longint'(trk_if.x_duty), 150000);
        check("home_tracking", longint'(trk_if.tracking), 0);
        idle_ticks(2);

        // Edge in the tick cycle: held over to the following tick
        wait_tick(c);
        trk_if.x_pos           = 10'd500;
        trk_if.y_pos           = 10'd240;
        trk_if.coor_valid_flag = 1'b1;
        @(posedge clk);
        #1;
        trk_if.coor_valid_flag = 1'b0;
        @(negedge clk);
        check("coinc_no_upd", longint'(trk_if.duty_upd), 0);
        check("coinc_x_held", longint'(trk_if.x_duty), 150000);
        exp_q.push_back('{ex: 18'd149600, ey: 18'd150000});
        wait_tick(c);
        @(negedge clk);
        #1;
        check("coinc_drained", exp_q.size(), 0);
        check("coinc_tracking", longint'(trk_if.tracking), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
